// File: rtl/tag_release_queue.sv
// In-order release queue: rename pushes old physical tags, commit retires them to the freelist.
// Optional underflow/overflow checking is enabled by defining RELQ_CHECK_EN.
module tag_release_queue #(
  parameter int DEPTH     = 32,
  parameter int DEPTH_SEL = 5,
  parameter int FREE_SEL  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_en_1,
  input  logic                push_en_2,
  input  logic                push_rel_1,
  input  logic                push_rel_2,
  input  logic [FREE_SEL-1:0] push_tag_1,
  input  logic [FREE_SEL-1:0] push_tag_2,
  input  logic [1:0]          commit_num,
  input  logic                prmiss,
  output logic                stall,
  output logic [FREE_SEL-1:0] released_1,
  output logic [FREE_SEL-1:0] released_2,
  output logic                released_valid_1,
  output logic                released_valid_2,
  output logic [DEPTH_SEL:0]  count,
  output logic                err
);

  logic                rel_mem [DEPTH];
  logic [FREE_SEL-1:0] tag_mem [DEPTH];

  logic [DEPTH_SEL-1:0] head_reg, tail_reg;
  logic [DEPTH_SEL:0]   count_reg;

  logic [1:0]           pushnum;
  logic [DEPTH_SEL+1:0] count_sum;
  logic [1:0]           commit_req;
  logic [1:0]           eff;
  logic                 accept;
  logic [DEPTH_SEL-1:0] head_p1;
  logic [DEPTH_SEL-1:0] head_next;
  logic [DEPTH_SEL-1:0] wr_idx_2;
  logic [DEPTH_SEL:0]   push_add;

  assign pushnum    = {1'b0, push_en_1} + {1'b0, push_en_2};
  assign count_sum  = {1'b0, count_reg} + {{DEPTH_SEL{1'b0}}, pushnum};
  // Space is judged on registered occupancy only; same-cycle commits do not help.
  assign stall      = count_sum > (DEPTH_SEL+2)'(DEPTH);
  assign commit_req = (commit_num > 2'd2) ? 2'd2 : commit_num;
  assign eff        = (count_reg < {{(DEPTH_SEL-1){1'b0}}, commit_req}) ? count_reg[1:0] : commit_req;
  assign accept     = !stall && !prmiss;
  assign head_p1    = head_reg + DEPTH_SEL'(1);
  assign head_next  = head_reg + {{(DEPTH_SEL-2){1'b0}}, eff};
  assign wr_idx_2   = tail_reg + {{(DEPTH_SEL-1){1'b0}}, push_en_1};
  assign push_add   = accept ? {{(DEPTH_SEL-1){1'b0}}, pushnum} : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      released_1       <= '0;
      released_2       <= '0;
      released_valid_1 <= 1'b0;
      released_valid_2 <= 1'b0;
    end else begin
      released_1       <= tag_mem[head_reg];
      released_2       <= tag_mem[head_p1];
      released_valid_1 <= (eff >= 2'd1) && rel_mem[head_reg];
      released_valid_2 <= (eff == 2'd2) && rel_mem[head_p1];
      head_reg         <= head_next;
      if (prmiss) begin
        // Everything not retiring this cycle is speculative and discarded.
        tail_reg  <= head_next;
        count_reg <= '0;
      end else begin
        tail_reg  <= tail_reg + push_add[DEPTH_SEL-1:0];
        count_reg <= count_reg + push_add - {{(DEPTH_SEL-1){1'b0}}, eff};
      end
    end
  end

  // Entry storage carries no reset; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (accept && push_en_1) begin
      rel_mem[tail_reg] <= push_rel_1;
      tag_mem[tail_reg] <= push_tag_1;
    end
    if (accept && push_en_2) begin
      rel_mem[wr_idx_2] <= push_rel_2;
      tag_mem[wr_idx_2] <= push_tag_2;
    end
  end

  assign count = count_reg;

`ifdef RELQ_CHECK_EN
  logic err_reg;
  logic underflow;
  logic overflow;

  assign underflow = {{(DEPTH_SEL-1){1'b0}}, commit_num} > count_reg;
  assign overflow  = (pushnum != 2'd0) && stall && !prmiss;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (underflow || overflow) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_release_queue.sv
// Directed bench for tag_release_queue with hand-computed expected values.
module tb_tag_release_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       push_en_1, push_en_2, push_rel_1, push_rel_2;
  logic [5:0] push_tag_1, push_tag_2;
  logic [1:0] commit_num;
  logic       prmiss;
  logic       stall;
  logic [5:0] released_1, released_2;
  logic       released_valid_1, released_valid_2;
  logic [5:0] count;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic err_exp = 1'b0;

  tag_release_queue #(.DEPTH(32), .DEPTH_SEL(5), .FREE_SEL(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .push_en_1        (push_en_1),
    .push_en_2        (push_en_2),
    .push_rel_1       (push_rel_1),
    .push_rel_2       (push_rel_2),
    .push_tag_1       (push_tag_1),
    .push_tag_2       (push_tag_2),
    .commit_num       (commit_num),
    .prmiss           (prmiss),
    .stall            (stall),
    .released_1       (released_1),
    .released_2       (released_2),
    .released_valid_1 (released_valid_1),
    .released_valid_2 (released_valid_2),
    .count            (count),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic drive(input logic e1, input logic r1, input logic [5:0] t1,
                       input logic e2, input logic r2, input logic [5:0] t2,
                       input logic [1:0] cn, input logic pm);
    push_en_1  = e1; push_rel_1 = r1; push_tag_1 = t1;
    push_en_2  = e2; push_rel_2 = r2; push_tag_2 = t2;
    commit_num = cn; prmiss = pm;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("cycle t=%0t count=%0d v1=%0d r1=%0d v2=%0d r2=%0d err=%0d",
             $time, count, released_valid_1, released_1, released_valid_2, released_2, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_value("rst_count", 32'(count), 0);
    check_value("rst_v1", 32'(released_valid_1), 0);
    check_value("rst_v2", 32'(released_valid_2), 0);
    check_value("rst_r1", 32'(released_1), 0);
    check_value("rst_err", 32'(err), 0);
    #9;
    reset = 1'b1;
    step();

    // Basic push of two, then retire both.
    drive(1, 1, 6'd5, 1, 1, 6'd9, 0, 0);
    step();
    check_value("push2_count", 32'(count), 2);
    drive(0, 0, 0, 0, 0, 0, 2, 0);
    step();
    check_value("pop2_r1", 32'(released_1), 5);
    check_value("pop2_v1", 32'(released_valid_1), 1);
    check_value("pop2_r2", 32'(released_2), 9);
    check_value("pop2_v2", 32'(released_valid_2), 1);
    check_value("pop2_count", 32'(count), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_value("idle_v1", 32'(released_valid_1), 0);
    check_value("idle_v2", 32'(released_valid_2), 0);

    // Head entry without a release, second with one.
    drive(1, 0, 6'd3, 1, 1, 6'd12, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 2, 0);
    step();
    check_value("norel_v1", 32'(released_valid_1), 0);
    check_value("norel_v2", 32'(released_valid_2), 1);
    check_value("norel_r2", 32'(released_2), 12);
    check_value("norel_count", 32'(count), 0);

    // Simultaneous push and pop at count 2.
    drive(1, 1, 6'd20, 1, 1, 6'd21, 0, 0);
    step();
    drive(1, 1, 6'd22, 1, 1, 6'd23, 2, 0);
    check_value("pp_stall", 32'(stall), 0);
    step();
    check_value("pp_count", 32'(count), 2);
    check_value("pp_r1", 32'(released_1), 20);
    check_value("pp_r2", 32'(released_2), 21);
    check_value("pp_v", 32'({released_valid_1, released_valid_2}), 3);
    drive(0, 0, 0, 0, 0, 0, 2, 0);
    step();
    check_value("pp2_r1", 32'(released_1), 22);
    check_value("pp2_r2", 32'(released_2), 23);
    check_value("pp2_count", 32'(count), 0);

    // Fill to 31 starting at index 8, so the contents wrap 31 -> 0.
    for (int i = 0; i < 15; i++) begin
      drive(1, 1, 6'(2*i+1), 1, 1, 6'(2*i+2), 0, 0);
      step();
    end
    drive(1, 1, 6'd31, 0, 0, 0, 0, 0);
    step();
    check_value("fill_count", 32'(count), 31);
    drive(1, 1, 6'd41, 1, 1, 6'd42, 0, 0);
    check_value("fill_stall2", 32'(stall), 1);
    step();
`ifdef RELQ_CHECK_EN
    err_exp = 1'b1;
`endif
    check_value("stall_count", 32'(count), 31);
    check_value("stall_err", 32'(err), 32'(err_exp));
    drive(1, 1, 6'd40, 0, 0, 0, 0, 0);
    check_value("fill_stall1", 32'(stall), 0);
    step();
    check_value("full_count", 32'(count), 32);
    drive(1, 1, 6'd43, 0, 0, 0, 0, 0);
    check_value("full_stall", 32'(stall), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 0, 0, 0, 0, 2, 0);
      step();
      check_value("drain_r1", 32'(released_1), 32'(2*k+1));
      check_value("drain_r2", 32'(released_2), (k == 15) ? 32'd40 : 32'(2*k+2));
      check_value("drain_v", 32'({released_valid_1, released_valid_2}), 3);
    end
    check_value("drain_count", 32'(count), 0);

    // Misprediction at count 6 with one commit and dropped pushes.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 6'(50+2*i), 1, 1, 6'(51+2*i), 0, 0);
      step();
    end
    check_value("pm_pre_count", 32'(count), 6);
    drive(1, 1, 6'd60, 1, 1, 6'd61, 1, 1);
    step();
    check_value("pm_v1", 32'(released_valid_1), 1);
    check_value("pm_r1", 32'(released_1), 50);
    check_value("pm_v2", 32'(released_valid_2), 0);
    check_value("pm_count", 32'(count), 0);
    drive(1, 1, 6'd62, 1, 1, 6'd63, 0, 0);
    step();
    check_value("pm_post_count", 32'(count), 2);
    drive(0, 0, 0, 0, 0, 0, 2, 0);
    step();
    check_value("pm_post_r1", 32'(released_1), 62);
    check_value("pm_post_r2", 32'(released_2), 63);
    check_value("pm_post_v", 32'({released_valid_1, released_valid_2}), 3);
    check_value("pm_err", 32'(err), 32'(err_exp));

    // Commit of two with only one entry present.
    drive(1, 1, 6'd7, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 2, 0);
    step();
`ifdef RELQ_CHECK_EN
    err_exp = 1'b1;
`endif
    check_value("uf_v1", 32'(released_valid_1), 1);
    check_value("uf_r1", 32'(released_1), 7);
    check_value("uf_v2", 32'(released_valid_2), 0);
    check_value("uf_count", 32'(count), 0);
    check_value("uf_err", 32'(err), 32'(err_exp));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_value("uf_err_hold", 32'(err), 32'(err_exp));

    // Asynchronous reset mid-cycle.
    drive(1, 1, 6'd8, 0, 0, 0, 0, 0);
    step();
    #2;
    reset = 1'b0;
    #1;
    check_value("arst_count", 32'(count), 0);
    check_value("arst_err", 32'(err), 0);
    check_value("arst_v1", 32'(released_valid_1), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
